alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU between two independent requesters, e.g. the core execute path and a debug/CSR helper. Each requester issues an operation over a valid/ready request channel and receives a registered result over a valid/ready response channel. Arbitration is round-robin, and only one operation is in flight at a time. The ALU operand/opcode inputs are driven from registers, and the ALU result/zero outputs are sampled back into this block.

Parameters:
- DATA_WIDTH, 32, operand and result width
- OP_WIDTH, 4, ALU opcode width; opcodes pass through to the ALU unmodified

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OP_WIDTH  requester 0 ALU opcode
- req0_a  in  DATA_WIDTH  requester 0 operand A
- req0_b  in  DATA_WIDTH  requester 0 operand B
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for requester 1
- rsp1_valid, rsp1_ready  same as port 0, for requester 1
- rsp_result  out  DATA_WIDTH  shared result bus, meaningful while rspN_valid is asserted
- rsp_zero  out  1  shared zero flag, paired with rsp_result
- alu_operand_a  out  DATA_WIDTH  to ALU operand A (registered)
- alu_operand_b  out  DATA_WIDTH  to ALU operand B (registered)
- alu_op  out  OP_WIDTH  to ALU opcode (registered)
- alu_result  in  DATA_WIDTH  from ALU result
- alu_zero  in  1  from ALU zero flag
- busy  out  1  high in EXEC or RESP
- grant_id  out  1  index of the requester currently owning the ALU

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset values:
  - state = IDLE, rr_ptr = 0 (port 0 has priority first)
  - alu_operand_a/b = 0, alu_op = 0, rsp_result = 0, rsp_zero = 0, grant_id = 0
  - all valid/ready outputs = 0, busy = 0
- IDLE:
  - Winner is chosen combinationally. If only one reqN_valid is high, that port wins. If both are high, port rr_ptr wins.
  - reqN_ready is high only for the winner, only in IDLE. It may depend combinationally on reqN_valid.
  - On handshake (valid && ready): latch the winner's op/a/b into alu_op/alu_operand_a/alu_operand_b, set grant_id = winner, go to EXEC.
  - With no valid, stay in IDLE and hold all registers.
- EXEC (exactly 1 cycle):
  - The ALU sees the registered inputs for the whole cycle.
  - On the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rsp{grant_id}_valid = 1; the other rsp valid = 0.
  - rsp_result/rsp_zero are held stable until the handshake.
  - On rsp{grant_id}_ready: go to IDLE and set rr_ptr = ~grant_id, so the other port gets priority next.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Request acceptance to rspN_valid: 2 cycles.
  - Minimum 3 cycles per operation when rsp_ready is held high.
  - No requester can be starved while the other is continuously valid.
- Input stability: the requester may change or drop req inputs at any time before its handshake. Only values present at the handshake edge are used.
- ALU inputs hold their last latched values outside EXEC; no toggling is required.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is issued. Every output returns to its reset value on the next edge.
- All arithmetic semantics belong to the ALU; this block never inspects the opcode or operands.

Test Plan:
- Single op: rst low; req0 op=ADD, a=5, b=7, held valid; rsp0_ready=1.
  -> req0_ready high in the first cycle; rsp0_valid exactly 2 cycles after the handshake; rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
- Zero flag: req1 op=SUB, a=b=0x1234.
  -> rsp1_valid with rsp_result=0, rsp_zero=1; grant_id=1 throughout busy.
- Contention and round-robin: both ports continuously valid from reset, rsp ready always high.
  -> grants alternate 0,1,0,1 over 4 ops, each spaced 3 cycles apart; every result matches its port's operands.
- Response backpressure: rsp0_ready held low for 5 cycles in RESP while req1_valid=1.
  -> rsp0_valid and rsp_result stay stable; req1_ready stays 0 until the cycle after rsp0 handshakes, then req1 is granted.
- Reset mid-op: assert rst during EXEC.
  -> next cycle state=IDLE, busy=0, rsp_valids=0, alu_operand_a/b=0, rr_ptr=0; no stale response appears afterwards.
- Operand change before acceptance: req1 changes a from 3 to 9 while port 0 owns the ALU.
  -> the port 1 result reflects a=9, the value present at its handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: accept in IDLE, drive ALU in EXEC, hold the result in RESP.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,

    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,

    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,

    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  grant_id_q, grant_id_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;

    logic winner;
    logic accept;
    logic rsp_taken;

    // With a single valid requester it wins outright; on contention rr_ptr decides.
    always_comb begin
        winner = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    end

    assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !winner;
    assign req1_ready = (state_q == IDLE) && !rst && req1_valid &&  winner;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = (state_q == RESP) && !grant_id_q;
    assign rsp1_valid = (state_q == RESP) &&  grant_id_q;
    assign rsp_taken  = grant_id_q ? rsp1_ready : rsp0_ready;

    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_id_q;
    assign alu_op        = alu_op_q;
    assign alu_operand_a = alu_a_q;
    assign alu_operand_b = alu_b_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_op_d   = winner ? req1_op : req0_op;
                    alu_a_d    = winner ? req1_a  : req0_a;
                    alu_b_d    = winner ? req1_b  : req0_b;
                    grant_id_d = winner;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                state_d      = RESP;
            end
            RESP: begin
                // Handing priority to the other port is what prevents starvation.
                if (rsp_taken) begin
                    rr_ptr_d = ~grant_id_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            grant_id_q   <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, latency and results.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [OW-1:0] req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;
    logic [DW-1:0] alu_operand_a, alu_operand_b, alu_result;
    logic [OW-1:0] alu_op;
    logic          alu_zero, busy, grant_id;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    // Small ALU used both as the DUT's attached ALU and as the reference for results.
    function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            default: return ~a;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_op, alu_operand_a, alu_operand_b);
        alu_zero   = (alu_result == '0);
    end

    // {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id}
    function automatic logic [5:0] ctl();
        return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b000000) $display("FAIL reset_ctl: got %b want %b", ctl(), 6'b000000);
        else n_pass++;
        n_checks++;
        if ({alu_op, alu_operand_a, alu_operand_b, rsp_result, rsp_zero} !== '0)
            $display("FAIL reset_regs: op=%h a=%h b=%h res=%h z=%b want all 0",
                     alu_op, alu_operand_a, alu_operand_b, rsp_result, rsp_zero);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        settle();
        n_checks++;
        if (ctl() !== 6'b000000) $display("FAIL reset_idle: got %b want %b", ctl(), 6'b000000);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_single_op();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
        settle();
        n_checks++;
        if (ctl() !== 6'b100000) $display("FAIL single_accept: got %b want %b", ctl(), 6'b100000);
        else n_pass++;
        next_cycle();
        req0_valid = 1'b0;
        settle();
        n_checks++;
        if (ctl() !== 6'b000010) $display("FAIL single_exec: got %b want %b", ctl(), 6'b000010);
        else n_pass++;
        n_checks++;
        if ({alu_op, alu_operand_a, alu_operand_b} !== {4'd0, 32'd5, 32'd7})
            $display("FAIL single_alu_in: got op=%0d a=%0d b=%0d want 0/5/7", alu_op, alu_operand_a, alu_operand_b);
        else n_pass++;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b001010) $display("FAIL single_resp: got %b want %b", ctl(), 6'b001010);
        else n_pass++;
        n_checks++;
        if ({rsp_result, rsp_zero} !== {32'd12, 1'b0})
            $display("FAIL single_result: got %0d z=%b want 12 z=0", rsp_result, rsp_zero);
        else n_pass++;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b000000) $display("FAIL single_done: got %b want %b", ctl(), 6'b000000);
        else n_pass++;
        rsp0_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero_flag();
        logic [5:0] exp_ctl [4];
        exp_ctl[0] = 6'b010000; exp_ctl[1] = 6'b000011; exp_ctl[2] = 6'b000111; exp_ctl[3] = 6'b000001;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h1234; req1_b = 32'h1234; rsp1_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if (ctl() !== exp_ctl[c]) $display("FAIL zero_ctl_c%0d: got %b want %b", c, ctl(), exp_ctl[c]);
            else n_pass++;
            if (c == 2) begin
                n_checks++;
                if ({rsp_result, rsp_zero} !== {32'd0, 1'b1})
                    $display("FAIL zero_result: got %h z=%b want 0 z=1", rsp_result, rsp_zero);
                else n_pass++;
            end
            next_cycle();
            req1_valid = 1'b0;
        end
        rsp1_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_res [2];
        logic [5:0]    exp;
        logic          p;
        int            ph;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = $urandom; req1_b = $urandom;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_res[0] = req0_a + req0_b;
        exp_res[1] = req1_a ^ req1_b;
        for (int c = 0; c < 12; c++) begin
            p  = ((c / 3) % 2) == 1;
            ph = c % 3;
            settle();
            if (ph == 0) exp = {!p, p, 1'b0, 1'b0, 1'b0, (c == 0) ? 1'b0 : !p};
            else if (ph == 1) exp = {4'b0000, 1'b1, p};
            else exp = {2'b00, !p, p, 1'b1, p};
            n_checks++;
            if (ctl() !== exp) $display("FAIL rr_ctl_c%0d: got %b want %b", c, ctl(), exp);
            else n_pass++;
            if (ph == 2) begin
                n_checks++;
                if (rsp_result !== exp_res[p])
                    $display("FAIL rr_result_c%0d: got %h want %h", c, rsp_result, exp_res[p]);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp0, exp1;
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = $urandom; req0_b = $urandom;
        exp0 = req0_a & req0_b;
        settle();
        n_checks++;
        if (ctl() !== 6'b100000) $display("FAIL bp_accept0: got %b want %b", ctl(), 6'b100000);
        else n_pass++;
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = $urandom; req1_b = $urandom;
        exp1 = req1_a + req1_b;
        settle();
        n_checks++;
        if (ctl() !== 6'b000010) $display("FAIL bp_exec: got %b want %b", ctl(), 6'b000010);
        else n_pass++;
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) rsp0_ready = 1'b1;
            settle();
            n_checks++;
            if (ctl() !== 6'b001010 || rsp_result !== exp0)
                $display("FAIL bp_hold_c%0d: ctl=%b res=%h want ctl=%b res=%h", c, ctl(), rsp_result, 6'b001010, exp0);
            else n_pass++;
            next_cycle();
        end
        rsp0_ready = 1'b0;
        settle();
        n_checks++;
        if (ctl() !== 6'b010000) $display("FAIL bp_accept1: got %b want %b", ctl(), 6'b010000);
        else n_pass++;
        next_cycle();
        req1_valid = 1'b0; rsp1_ready = 1'b1;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b000111 || rsp_result !== exp1)
            $display("FAIL bp_resp1: ctl=%b res=%h want ctl=%b res=%h", ctl(), rsp_result, 6'b000111, exp1);
        else n_pass++;
        next_cycle();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        // One port-0 op first so the pointer moves to port 1 before the reset.
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2; rsp0_ready = 1'b1;
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        next_cycle();
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd40; req1_b = 32'd2; rsp1_ready = 1'b1;
        settle();
        n_checks++;
        if (ctl() !== 6'b010000) $display("FAIL midrst_accept1: got %b want %b", ctl(), 6'b010000);
        else n_pass++;
        next_cycle();
        req1_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b000000) $display("FAIL midrst_ctl: got %b want %b", ctl(), 6'b000000);
        else n_pass++;
        n_checks++;
        if ({alu_op, alu_operand_a, alu_operand_b, rsp_result, rsp_zero} !== '0)
            $display("FAIL midrst_regs: op=%h a=%h b=%h res=%h want all 0", alu_op, alu_operand_a, alu_operand_b, rsp_result);
        else n_pass++;
        rst = 1'b0;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++;
            if (ctl() !== 6'b000000) $display("FAIL midrst_stale_c%0d: got %b want %b", c, ctl(), 6'b000000);
            else n_pass++;
            next_cycle();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        n_checks++;
        if (ctl() !== 6'b100000) $display("FAIL midrst_ptr: got %b want %b", ctl(), 6'b100000);
        else n_pass++;
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
        rsp0_ready = 1'b1;
        next_cycle();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_operand_change();
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = $urandom; req0_b = $urandom; rsp0_ready = 1'b1;
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd3; req1_b = 32'd100;
        next_cycle();
        req1_a = 32'd9;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b010000) $display("FAIL opchg_accept1: got %b want %b", ctl(), 6'b010000);
        else n_pass++;
        next_cycle();
        req1_valid = 1'b0; req1_a = 32'd3; rsp1_ready = 1'b1;
        settle();
        n_checks++;
        if (alu_operand_a !== 32'd9) $display("FAIL opchg_alu_a: got %0d want 9", alu_operand_a);
        else n_pass++;
        next_cycle();
        settle();
        n_checks++;
        if (ctl() !== 6'b000111 || rsp_result !== 32'd109)
            $display("FAIL opchg_result: ctl=%b res=%0d want ctl=%b res=109", ctl(), rsp_result, 6'b000111);
        else n_pass++;
        next_cycle();
        rsp1_ready = 1'b0;
    endtask

    // Transaction-level model: one pending op, known age since acceptance.
    task automatic test_random();
        logic          m_ptr = 1'b0, m_gid = 1'b0, pend = 1'b0, owner = 1'b0, win;
        logic          er0, er1;
        int            age = 0;
        logic [OW-1:0] last_op = '0;
        logic [DW-1:0] last_a = '0, last_b = '0, exp_res = '0;
        logic [5:0]    exp;
        int            errs_before;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op = OW'($urandom_range(0, 7)); req0_a = $urandom; req0_b = $urandom;
            req1_op = OW'($urandom_range(0, 7)); req1_a = $urandom; req1_b = $urandom;
            if ($urandom_range(0, 7) == 0) req0_b = req0_a;
            if ($urandom_range(0, 7) == 0) req1_b = req1_a;
            rsp0_ready = ($urandom_range(0, 1) == 1);
            rsp1_ready = ($urandom_range(0, 1) == 1);
            settle();
            win = 1'b0; er0 = 1'b0; er1 = 1'b0;
            if (!pend) begin
                win = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                er0 = req0_valid && !win;
                er1 = req1_valid && win;
                exp = {er0, er1, 3'b000, m_gid};
            end else if (age == 1) begin
                exp = {4'b0000, 1'b1, m_gid};
            end else begin
                exp = {2'b00, !owner, owner, 1'b1, m_gid};
            end
            errs_before = n_checks - n_pass;
            n_checks++;
            if (ctl() !== exp) $display("FAIL rand_ctl_c%0d: got %b want %b", c, ctl(), exp);
            else n_pass++;
            n_checks++;
            if ({alu_op, alu_operand_a, alu_operand_b} !== {last_op, last_a, last_b})
                $display("FAIL rand_alu_in_c%0d: got %h/%h/%h want %h/%h/%h", c,
                         alu_op, alu_operand_a, alu_operand_b, last_op, last_a, last_b);
            else n_pass++;
            if (pend && age >= 2) begin
                n_checks++;
                if ({rsp_result, rsp_zero} !== {exp_res, exp_res == '0})
                    $display("FAIL rand_result_c%0d: got %h z=%b want %h z=%b", c,
                             rsp_result, rsp_zero, exp_res, exp_res == '0);
                else n_pass++;
            end
            if (n_checks - n_pass > errs_before + 20) break;
            if (!pend) begin
                if (er0 || er1) begin
                    pend    = 1'b1;
                    age     = 1;
                    owner   = win;
                    m_gid   = win;
                    last_op = win ? req1_op : req0_op;
                    last_a  = win ? req1_a  : req0_a;
                    last_b  = win ? req1_b  : req0_b;
                    exp_res = alu_ref(last_op, last_a, last_b);
                end
            end else if (age >= 2 && (owner ? rsp1_ready : rsp0_ready)) begin
                pend  = 1'b0;
                m_ptr = !owner;
            end else begin
                age++;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        test_reset();
        test_single_op();
        test_zero_flag();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
